// File: rtl/adc_parallel_readout.sv
`default_nettype none
// ============================================================================
// Module      : adc_parallel_readout
// Description : Reads NUM_CH conversion results from an ADC over its 16-bit
//               parallel bus after each BUSY falling edge, driving the CS/RD
//               strobes. Samples are presented one at a time on a valid/ready
//               stream, tagged with their channel index. A new conversion
//               starting mid-frame aborts the readout and raises a sticky
//               overrun flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          system clock
//   reset_i        asynchronous, active-high reset
//   en_i           enable; low blocks new frames and aborts an active one
//   busy_i         ADC BUSY (asynchronous to clk_i)
//   adc_db_i       ADC parallel data bus
//   adc_cs_n_o     ADC chip select, active low
//   adc_rd_n_o     ADC read strobe, active low
//   sample_o       captured sample
//   chan_o         channel index of sample_o
//   valid_o        sample_o/chan_o valid
//   ready_i        consumer ready
//   frame_done_o   one-cycle pulse after a complete frame
//   overrun_o      sticky overrun flag
//   overrun_clr_i  clears overrun_o (a simultaneous set wins)
// ============================================================================
module adc_parallel_readout #(
    parameter int NUM_CH         = 8,
    parameter int RD_LOW_CYCLES  = 3,
    parameter int RD_HIGH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        en_i,
    input  logic        busy_i,
    input  logic [15:0] adc_db_i,
    output logic        adc_cs_n_o,
    output logic        adc_rd_n_o,
    output logic [15:0] sample_o,
    output logic [2:0]  chan_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        frame_done_o,
    output logic        overrun_o,
    input  logic        overrun_clr_i
);

    // Phase counter only needs to reach the longer of the two strobe phases.
    localparam int c_CNT_MAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_LOW_LAST  = c_CNT_W'(RD_LOW_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HIGH_LAST = c_CNT_W'(RD_HIGH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [2:0]         c_LAST_CH   = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_LOW  = 2'd1,
        S_STALL   = 2'd2,
        S_RD_HIGH = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]           r_ch;
    logic [2:0]           w_ch_nxt;
    logic                 w_capture;
    logic                 w_frame_done_nxt;
    logic                 w_overrun_set;

    logic                 r_busy_meta;
    logic                 r_busy_s;
    logic                 r_busy_d;
    logic                 w_fall;
    logic                 w_rise;
    logic                 w_slot_free;

    logic                 r_cs_n;
    logic                 r_rd_n;
    logic [15:0]          r_sample;
    logic [2:0]           r_chan;
    logic                 r_valid;
    logic                 r_frame_done;
    logic                 r_overrun;

    // ------------------------------------------------------------------------
    // BUSY synchronizer plus one history flop for edge detection
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_busy_meta <= 1'b0;
            r_busy_s    <= 1'b0;
            r_busy_d    <= 1'b0;
        end else begin
            r_busy_meta <= busy_i;
            r_busy_s    <= r_busy_meta;
            r_busy_d    <= r_busy_s;
        end
    end

    assign w_fall = r_busy_d & ~r_busy_s;
    assign w_rise = ~r_busy_d & r_busy_s;

    // The output slot can take a new sample if it is empty or being drained
    // on this very edge.
    assign w_slot_free = ~r_valid | ready_i;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ch    <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ch    <= w_ch_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state. A new conversion (overrun) outranks an enable drop, and
    // both outrank normal sequencing.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_ch_nxt         = r_ch;
        w_capture        = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_overrun_set    = 1'b0;

        if ((r_state != S_IDLE) && w_rise) begin
            w_state_nxt   = S_IDLE;
            w_overrun_set = 1'b1;
        end else if ((r_state != S_IDLE) && !en_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fall && en_i) begin
                        w_state_nxt = S_RD_LOW;
                        w_cnt_nxt   = '0;
                        w_ch_nxt    = 3'd0;
                    end
                end
                S_RD_LOW: begin
                    if (r_cnt == c_LOW_LAST) begin
                        if (w_slot_free) begin
                            w_capture   = 1'b1;
                            w_state_nxt = S_RD_HIGH;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = S_STALL;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                S_STALL: begin
                    // rd_n stays low so the ADC keeps driving the result.
                    if (w_slot_free) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_RD_HIGH;
                        w_cnt_nxt   = '0;
                    end
                end
                S_RD_HIGH: begin
                    if (r_cnt == c_HIGH_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_ch == c_LAST_CH) begin
                            w_state_nxt      = S_IDLE;
                            w_frame_done_nxt = 1'b1;
                        end else begin
                            w_ch_nxt    = r_ch + 3'd1;
                            w_state_nxt = S_RD_LOW;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs. Strobes are decoded from the next state so they are
    // glitch-free flop outputs aligned with the state they belong to.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cs_n       <= 1'b1;
            r_rd_n       <= 1'b1;
            r_sample     <= 16'd0;
            r_chan       <= 3'd0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_cs_n       <= (w_state_nxt == S_IDLE);
            r_rd_n       <= !((w_state_nxt == S_RD_LOW) || (w_state_nxt == S_STALL));
            r_frame_done <= w_frame_done_nxt;

            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr_i) begin
                r_overrun <= 1'b0;
            end

            if (w_capture) begin
                r_sample <= adc_db_i;
                r_chan   <= r_ch;
                r_valid  <= 1'b1;
            end else if (ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign adc_cs_n_o   = r_cs_n;
    assign adc_rd_n_o   = r_rd_n;
    assign sample_o     = r_sample;
    assign chan_o       = r_chan;
    assign valid_o      = r_valid;
    assign frame_done_o = r_frame_done;
    assign overrun_o    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_adc_parallel_readout.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_adc_parallel_readout
// Description : Self-checking bench for adc_parallel_readout. A behavioural
//               ADC drives base+channel on each RD_N falling edge and random
//               data while RD_N is high; monitors log accepted samples, strobe
//               phase lengths and frame_done timing for the tests to compare
//               against expectations derived from the readout rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_parallel_readout;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        en_i;
    logic        busy_i;
    logic [15:0] adc_db_i;
    logic [15:0] adc_db1;
    logic        ready_i;
    logic        overrun_clr_i;

    logic        adc_cs_n_o, adc_rd_n_o, valid_o, frame_done_o, overrun_o;
    logic [15:0] sample_o;
    logic [2:0]  chan_o;

    logic        cs1_n, rd1_n, valid1, fd1, ov1;
    logic [15:0] sample1;
    logic [2:0]  chan1;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    adc_parallel_readout u_dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .busy_i(busy_i),
        .adc_db_i(adc_db_i), .adc_cs_n_o(adc_cs_n_o), .adc_rd_n_o(adc_rd_n_o),
        .sample_o(sample_o), .chan_o(chan_o), .valid_o(valid_o), .ready_i(ready_i),
        .frame_done_o(frame_done_o), .overrun_o(overrun_o), .overrun_clr_i(overrun_clr_i)
    );

    adc_parallel_readout #(.NUM_CH(1), .RD_LOW_CYCLES(1), .RD_HIGH_CYCLES(1)) u_dut1 (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .busy_i(busy_i),
        .adc_db_i(adc_db1), .adc_cs_n_o(cs1_n), .adc_rd_n_o(rd1_n),
        .sample_o(sample1), .chan_o(chan1), .valid_o(valid1), .ready_i(ready_i),
        .frame_done_o(fd1), .overrun_o(ov1), .overrun_clr_i(overrun_clr_i)
    );

    // ---------------- behavioural ADC ----------------
    logic [15:0] frame_base = 16'h1000;
    int          adc_idx    = 0;
    always @(negedge adc_rd_n_o or posedge adc_rd_n_o or posedge adc_cs_n_o) begin
        if (!adc_rd_n_o) begin
            adc_db_i = frame_base + 16'(adc_idx);
            adc_idx++;
        end else begin
            adc_db_i = 16'($urandom);
        end
        if (adc_cs_n_o) adc_idx = 0;
    end

    // ---------------- monitors (sample on falling edge) ----------------
    logic [18:0] got_q[$];
    logic [18:0] got1_q[$];
    int          low_q[$];
    int          high_q[$];
    int          fd_q[$];
    int          fd1_q[$];
    int          cyc = 0, low_run = 0, high_run = 0;
    int          cs_fall_cyc = 0, cs1_fall_cyc = 0, cs_fall_cnt = 0, fd_wide = 0;
    logic        prev_cs = 1'b1, prev_cs1 = 1'b1, prev_fd = 1'b0;

    always @(negedge clk_i) begin
        cyc++;
        if (!adc_rd_n_o) low_run++;
        else if (low_run > 0) begin low_q.push_back(low_run); low_run = 0; end
        if (!adc_cs_n_o && adc_rd_n_o) high_run++;
        else if (high_run > 0) begin high_q.push_back(high_run); high_run = 0; end
        if (prev_cs && !adc_cs_n_o) begin cs_fall_cyc = cyc; cs_fall_cnt++; end
        if (prev_cs1 && !cs1_n) cs1_fall_cyc = cyc;
        if (frame_done_o) fd_q.push_back(cyc - cs_fall_cyc);
        if (frame_done_o && prev_fd) fd_wide++;
        if (fd1) fd1_q.push_back(cyc - cs1_fall_cyc);
        if (valid_o && ready_i) got_q.push_back({chan_o, sample_o});
        if (valid1 && ready_i) got1_q.push_back({chan1, sample1});
        prev_cs  = adc_cs_n_o;
        prev_cs1 = cs1_n;
        prev_fd  = frame_done_o;
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic clear_logs();
        got_q.delete(); got1_q.delete(); low_q.delete(); high_q.delete();
        fd_q.delete(); fd1_q.delete(); fd_wide = 0;
    endtask

    task automatic start_frame();
        busy_i = 1'b1;
        step(4);
        busy_i = 1'b0;
    endtask

    task automatic wait_fd(input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit && !ok; k++) begin
            step(1);
            if (fd_q.size() > 0) ok = 1'b1;
        end
    endtask

    task automatic wait_chan_valid(input logic [2:0] ch, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit && !ok; k++) begin
            step(1);
            if (valid_o && chan_o == ch) ok = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        checks += 7;
        if (adc_cs_n_o !== 1'b1)   begin errors++; $display("FAIL reset_cs_n: got %b expected 1", adc_cs_n_o); end
        if (adc_rd_n_o !== 1'b1)   begin errors++; $display("FAIL reset_rd_n: got %b expected 1", adc_rd_n_o); end
        if (sample_o !== 16'h0)    begin errors++; $display("FAIL reset_sample: got %h expected 0000", sample_o); end
        if (chan_o !== 3'd0)       begin errors++; $display("FAIL reset_chan: got %0d expected 0", chan_o); end
        if (valid_o !== 1'b0)      begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done_o); end
        if (overrun_o !== 1'b0)    begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
        @(negedge clk_i);
        reset_i = 1'b0;
        step(3);
    endtask

    task automatic test_frame_default();
        bit ok;
        clear_logs();
        frame_base = 16'h1000;
        ready_i    = 1'b1;
        start_frame();
        wait_fd(200, ok);
        step(3);
        checks++;
        if (!ok) begin errors++; $display("FAIL default_timeout: got no frame_done expected one"); end
        checks++;
        if (got_q.size() != 8) begin errors++; $display("FAIL default_count: got %0d expected 8", got_q.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_q[i] !== {3'(i), 16'h1000 + 16'(i)})
                begin errors++; $display("FAIL default_sample%0d: got %h expected %h", i, got_q[i], {3'(i), 16'h1000 + 16'(i)}); end
        end
        checks += 2;
        if (low_q.size() != 8)  begin errors++; $display("FAIL default_low_cnt: got %0d expected 8", low_q.size()); end
        if (high_q.size() != 8) begin errors++; $display("FAIL default_high_cnt: got %0d expected 8", high_q.size()); end
        for (int i = 0; i < 8; i++) begin
            checks += 2;
            if (low_q[i] != 3)  begin errors++; $display("FAIL default_low%0d: got %0d expected 3", i, low_q[i]); end
            if (high_q[i] != 2) begin errors++; $display("FAIL default_high%0d: got %0d expected 2", i, high_q[i]); end
        end
        checks += 4;
        if (fd_q.size() != 1) begin errors++; $display("FAIL default_fd_count: got %0d expected 1", fd_q.size()); end
        if (fd_q[0] != 40)    begin errors++; $display("FAIL default_fd_latency: got %0d expected 40", fd_q[0]); end
        if (fd_wide != 0)     begin errors++; $display("FAIL default_fd_width: got %0d wide pulses expected 0", fd_wide); end
        if (overrun_o !== 1'b0) begin errors++; $display("FAIL default_overrun: got %b expected 0", overrun_o); end
    endtask

    task automatic test_backpressure();
        bit ok, ok2;
        int hold, exp_low3;
        hold       = $urandom_range(4, 15);
        exp_low3   = (hold - 1 > 3) ? hold - 1 : 3;
        clear_logs();
        frame_base = 16'($urandom);
        ready_i    = 1'b1;
        start_frame();
        wait_chan_valid(3'd2, 100, ok);
        ready_i = 1'b0;
        step(hold);
        ready_i = 1'b1;
        wait_fd(200, ok2);
        step(3);
        checks++;
        if (!(ok && ok2)) begin errors++; $display("FAIL bp_timeout: got %b%b expected 11", ok, ok2); end
        checks++;
        if (got_q.size() != 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", got_q.size()); end
        for (int i = 0; i < 8; i++) begin
            checks += 2;
            if (got_q[i] !== {3'(i), frame_base + 16'(i)})
                begin errors++; $display("FAIL bp_sample%0d: got %h expected %h", i, got_q[i], {3'(i), frame_base + 16'(i)}); end
            if (low_q[i] != ((i == 3) ? exp_low3 : 3))
                begin errors++; $display("FAIL bp_low%0d: got %0d expected %0d (hold %0d)", i, low_q[i], (i == 3) ? exp_low3 : 3, hold); end
        end
        checks++;
        if (fd_q[0] != 40 + exp_low3 - 3) begin errors++; $display("FAIL bp_fd_latency: got %0d expected %0d", fd_q[0], 40 + exp_low3 - 3); end
    endtask

    task automatic test_random_ready();
        for (int f = 0; f < 3; f++) begin
            int k, stall_sum;
            clear_logs();
            frame_base = 16'($urandom);
            k = 0;
            while (k < 600 && !(fd_q.size() > 0 && !valid_o)) begin
                busy_i  = (k < 4);
                ready_i = ($urandom_range(0, 3) != 0);
                step(1);
                k++;
            end
            ready_i = 1'b1;
            step(2);
            checks += 3;
            if (k >= 600)            begin errors++; $display("FAIL rnd%0d_timeout: got %0d cycles expected <600", f, k); end
            if (got_q.size() != 8)   begin errors++; $display("FAIL rnd%0d_count: got %0d expected 8", f, got_q.size()); end
            if (high_q.size() != 8)  begin errors++; $display("FAIL rnd%0d_high_cnt: got %0d expected 8", f, high_q.size()); end
            stall_sum = 0;
            for (int i = 0; i < 8; i++) begin
                checks += 3;
                if (got_q[i] !== {3'(i), frame_base + 16'(i)})
                    begin errors++; $display("FAIL rnd%0d_sample%0d: got %h expected %h", f, i, got_q[i], {3'(i), frame_base + 16'(i)}); end
                if (low_q[i] < 3)   begin errors++; $display("FAIL rnd%0d_low%0d: got %0d expected >=3", f, i, low_q[i]); end
                if (high_q[i] != 2) begin errors++; $display("FAIL rnd%0d_high%0d: got %0d expected 2", f, i, high_q[i]); end
                stall_sum += low_q[i] - 3;
            end
            checks++;
            if (fd_q[0] != 40 + stall_sum) begin errors++; $display("FAIL rnd%0d_fd_latency: got %0d expected %0d", f, fd_q[0], 40 + stall_sum); end
        end
    endtask

    task automatic test_overrun();
        bit ok;
        int k;
        clear_logs();
        frame_base = 16'($urandom);
        ready_i    = 1'b1;
        start_frame();
        wait_chan_valid(3'd5, 100, ok);
        busy_i = 1'b1;
        k = 0;
        while (k < 4 && !(adc_cs_n_o && adc_rd_n_o)) begin step(1); k++; end
        checks += 2;
        if (!ok) begin errors++; $display("FAIL ovr_ch5_timeout: got none expected chan 5"); end
        if (!(adc_cs_n_o && adc_rd_n_o)) begin errors++; $display("FAIL ovr_abort: got cs_n=%b rd_n=%b expected 1 1", adc_cs_n_o, adc_rd_n_o); end
        step(5);
        checks += 3;
        if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun_o); end
        if (fd_q.size() != 0)   begin errors++; $display("FAIL ovr_no_fd: got %0d pulses expected 0", fd_q.size()); end
        if (got_q.size() != 6)  begin errors++; $display("FAIL ovr_count: got %0d expected 6", got_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_q[i] !== {3'(i), frame_base + 16'(i)})
                begin errors++; $display("FAIL ovr_sample%0d: got %h expected %h", i, got_q[i], {3'(i), frame_base + 16'(i)}); end
        end
        // let BUSY fall without starting a frame
        en_i = 1'b0; busy_i = 1'b0; step(6); en_i = 1'b1;
        overrun_clr_i = 1'b1; step(1); overrun_clr_i = 1'b0;
        checks++;
        if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun_o); end
        // second overrun with clear asserted on exactly the setting edge
        start_frame();
        k = 0;
        while (k < 20 && adc_cs_n_o) begin step(1); k++; end
        step(2);
        busy_i = 1'b1;
        step(2);
        overrun_clr_i = 1'b1;
        step(1);
        overrun_clr_i = 1'b0;
        checks += 2;
        if (adc_cs_n_o !== 1'b1) begin errors++; $display("FAIL ovr2_abort: got cs_n=%b expected 1", adc_cs_n_o); end
        if (overrun_o !== 1'b1)  begin errors++; $display("FAIL ovr_set_beats_clear: got %b expected 1", overrun_o); end
        en_i = 1'b0; busy_i = 1'b0; step(6); en_i = 1'b1;
        overrun_clr_i = 1'b1; step(1); overrun_clr_i = 1'b0;
        step(2);
    endtask

    task automatic test_enable();
        bit ok;
        int falls;
        clear_logs();
        falls = cs_fall_cnt;
        en_i  = 1'b0;
        start_frame();
        step(20);
        checks += 2;
        if (cs_fall_cnt != falls) begin errors++; $display("FAIL en_blocked: got %0d frames expected 0", cs_fall_cnt - falls); end
        if (got_q.size() != 0)    begin errors++; $display("FAIL en_blocked_samples: got %0d expected 0", got_q.size()); end
        en_i = 1'b1;
        step(4);
        checks++;
        if (cs_fall_cnt != falls) begin errors++; $display("FAIL en_late: got %0d frames expected 0", cs_fall_cnt - falls); end
        frame_base = 16'($urandom);
        start_frame();
        wait_chan_valid(3'd0, 100, ok);
        step(3);
        en_i = 1'b0;
        step(1);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL en_ch0_timeout: got none expected chan 0"); end
        if (!(adc_cs_n_o && adc_rd_n_o)) begin errors++; $display("FAIL en_abort: got cs_n=%b rd_n=%b expected 1 1", adc_cs_n_o, adc_rd_n_o); end
        step(4);
        en_i = 1'b1;
        step(2);
        checks += 4;
        if (got_q.size() != 1) begin errors++; $display("FAIL en_count: got %0d expected 1", got_q.size()); end
        if (got_q[0] !== {3'd0, frame_base}) begin errors++; $display("FAIL en_sample0: got %h expected %h", got_q[0], {3'd0, frame_base}); end
        if (fd_q.size() != 0)   begin errors++; $display("FAIL en_no_fd: got %0d expected 0", fd_q.size()); end
        if (overrun_o !== 1'b0) begin errors++; $display("FAIL en_overrun: got %b expected 0", overrun_o); end
    endtask

    task automatic test_async_reset();
        bit ok;
        clear_logs();
        frame_base = 16'($urandom);
        ready_i    = 1'b0;
        start_frame();
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin step(1); if (valid_o) ok = 1'b1; end
        step(8);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL ar_valid_timeout: got none expected valid"); end
        if (adc_rd_n_o !== 1'b0) begin errors++; $display("FAIL ar_stall_rd: got %b expected 0", adc_rd_n_o); end
        @(negedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        checks += 7;
        if (adc_cs_n_o !== 1'b1)   begin errors++; $display("FAIL ar_cs_n: got %b expected 1", adc_cs_n_o); end
        if (adc_rd_n_o !== 1'b1)   begin errors++; $display("FAIL ar_rd_n: got %b expected 1", adc_rd_n_o); end
        if (sample_o !== 16'h0)    begin errors++; $display("FAIL ar_sample: got %h expected 0000", sample_o); end
        if (chan_o !== 3'd0)       begin errors++; $display("FAIL ar_chan: got %0d expected 0", chan_o); end
        if (valid_o !== 1'b0)      begin errors++; $display("FAIL ar_valid: got %b expected 0", valid_o); end
        if (frame_done_o !== 1'b0) begin errors++; $display("FAIL ar_frame_done: got %b expected 0", frame_done_o); end
        if (overrun_o !== 1'b0)    begin errors++; $display("FAIL ar_overrun: got %b expected 0", overrun_o); end
        step(2);
        @(negedge clk_i);
        reset_i = 1'b0;
        ready_i = 1'b1;
        step(2);
        clear_logs();
        frame_base = 16'($urandom);
        start_frame();
        wait_fd(200, ok);
        step(3);
        checks += 2;
        if (got_q.size() != 8) begin errors++; $display("FAIL ar_frame_count: got %0d expected 8", got_q.size()); end
        if (fd_q[0] != 40)     begin errors++; $display("FAIL ar_fd_latency: got %0d expected 40", fd_q[0]); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got_q[i] !== {3'(i), frame_base + 16'(i)})
                begin errors++; $display("FAIL ar_sample%0d: got %h expected %h", i, got_q[i], {3'(i), frame_base + 16'(i)}); end
        end
    endtask

    task automatic test_num_ch1();
        bit ok;
        clear_logs();
        adc_db1    = 16'($urandom);
        frame_base = 16'($urandom);
        ready_i    = 1'b1;
        start_frame();
        wait_fd(200, ok);
        step(3);
        checks += 4;
        if (fd1_q.size() != 1)  begin errors++; $display("FAIL n1_fd_count: got %0d expected 1", fd1_q.size()); end
        if (fd1_q[0] != 2)      begin errors++; $display("FAIL n1_fd_latency: got %0d expected 2", fd1_q[0]); end
        if (got1_q.size() != 1) begin errors++; $display("FAIL n1_count: got %0d expected 1", got1_q.size()); end
        if (got1_q[0] !== {3'd0, adc_db1}) begin errors++; $display("FAIL n1_sample: got %h expected %h", got1_q[0], {3'd0, adc_db1}); end
    endtask

    initial begin
        reset_i       = 1'b1;
        en_i          = 1'b1;
        busy_i        = 1'b0;
        ready_i       = 1'b1;
        overrun_clr_i = 1'b0;
        adc_db1       = 16'hA5C3;
        test_reset();
        test_frame_default();
        test_backpressure();
        test_random_ready();
        test_overrun();
        test_enable();
        test_async_reset();
        test_num_ch1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
